wide_add_sequencer: RTL and testbench
=====================================

# wide_add_sequencer

Multi-precision add/subtract controller that time-shares one `adder32` instance across `WORDS` 32-bit limbs, one limb per clock, chaining the carry through a register. It accepts an operand pair over a valid/ready handshake, sequences the limbs LSW-first, and returns the full-width result, carry-out and signed-overflow flag over a second valid/ready handshake. It sits between the ALU front-end and the shared 32-bit adder and is the only block that drives that adder's inputs.

## Interface
- `WORDS`, default 4: number of 32-bit limbs; operand width `W = 32*WORDS`; legal range 2..16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand pair and mode present.
- `in_ready`  out  1  block can accept operands.
- `a`  in  W  operand A, unsigned or two's complement.
- `b`  in  W  operand B.
- `cin`  in  1  carry-in for add mode; ignored when `sub=1`.
- `sub`  in  1  0: S = A + B + cin; 1: S = A − B.
- `out_valid`  out  1  result registers valid.
- `out_ready`  in  1  consumer takes the result.
- `s`  out  W  result, registered.
- `cout`  out  1  carry out of the MSW. In sub mode 1 means no borrow.
- `ovf`  out  1  signed overflow of the full-width operation.

## Operation
- Internal: one `adder32` instance; operand registers `a_q`, `b_q`; limb index `idx` (`$clog2(WORDS)` bits); carry register `c_q`; result register `s`.
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid & in_ready`, latch `a`, `b`, `sub`. Set `c_q = sub ? 1 : cin` and `idx=0`. Go to RUN.
  - RUN: `in_ready=0`. Adder inputs are `a_q[idx]` and `sub ? ~b_q[idx] : b_q[idx]`, with carry-in `c_q`. Each edge: write `s[idx]` from the adder sum, `c_q <= adder cout`, `idx <= idx+1`.
    - On the edge where `idx == WORDS-1`, also latch `cout` from the adder cout.
    - On that same edge, latch `ovf = (A_msb == B'_msb) & (sum_msb != A_msb)`, where `B'` is `b` after the sub-mode inversion.
    - Then go to DONE.
  - DONE: `out_valid=1`; `in_ready=0`. On `out_ready`, go to IDLE.
- `s`, `cout` and `ovf` hold their values from DONE through IDLE until the next RUN overwrites them limb by limb.
- `s` is only guaranteed correct while `out_valid=1`. It is not cleared at acceptance.
- Arithmetic is modulo 2^W. No saturation.
- Inputs `a`, `b`, `cin` and `sub` are sampled only on the accepting edge. Later changes have no effect.

## Timing
- Reset values: state=IDLE, `in_ready=1`, `out_valid=0`, `s=0`, `cout=0`, `ovf=0`, `idx=0`, `c_q=0`.
- Latency: `out_valid` rises exactly `WORDS` edges after the accepting edge.
- Throughput: at most one operation per `WORDS+2` cycles with `out_ready` tied high. A new `in_valid` is accepted no earlier than the cycle after the `out_ready` handshake; there is no overlap.
- `in_valid` while `in_ready=0` is ignored, not queued. The source must hold it.
- `out_valid` stays high and `s`/`cout`/`ovf` stay stable for any number of cycles with `out_ready=0`.
- `out_ready` while `out_valid=0` has no effect.
- `rst` in any state, including mid-RUN: the next cycle shows reset values, the partial result is discarded, and no `out_valid` pulse occurs.
- Outputs `in_ready` and `out_valid` decode state only; there is no combinational path from `in_valid` or `out_ready`.

## Test plan
- Reset, then `WORDS=4`, `a=0`, `b=0`, `cin=0`, `sub=0`: `out_valid` rises 4 edges after acceptance with `s=0`, `cout=0`, `ovf=0`; `in_ready` returns to 1 one cycle after the `out_ready` handshake.
- Carry ripple: `a=128'hFFFF…FFFF`, `b=0`, `cin=1`: `s=0`, `cout=1`, `ovf=0`. Internal `c_q` is 1 after each RUN edge.
- Subtract:
  - `a=128'h1_00000000`, `b=1`, `sub=1`: `s=128'h0000…0000_FFFFFFFF`, `cout=1`.
  - `a=0`, `b=1`, `sub=1`: `s=all ones`, `cout=0`, `ovf=0`.
- Overflow: `a=128'h7FFF…FFFF`, `b=1`, `cin=0`: `s=128'h8000…0000`, `ovf=1`, `cout=0`.
- Backpressure and reset:
  - Hold `out_ready=0` for 5 cycles in DONE while pulsing `in_valid`: `out_valid` stays 1, `s` is unchanged, `in_ready` stays 0, and no new operation starts.
  - Assert `rst` on the 2nd RUN cycle: the next cycle has `in_ready=1`, `out_valid=0`, `s=0`.
- Random: 1024 operations with `$random` limbs, `cin` and `sub`, random `out_ready` stalls. Every result must match a behavioural `W+1`-bit sum and difference for `s`/`cout`, plus the sign-rule `ovf`. Zero mismatches required.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract controller: time-shares one 32-bit adder across
// WORDS limbs, LSW first, with the carry chained through a register.

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*WORDS-1:0] s,
    output logic                cout,
    output logic                ovf
);
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, next_state;

    logic [WORDS-1:0][31:0] a_q, b_q, s_q;
    logic                   sub_q;
    logic [IDX_W-1:0]       idx;
    logic                   c_q;

    logic [31:0] limb_a, limb_b, limb_sum;
    logic        limb_cout;
    logic        last_limb;

    // Subtraction is A + ~B + 1; the +1 comes from seeding c_q at acceptance.
    assign limb_a    = a_q[idx];
    assign limb_b    = sub_q ? ~b_q[idx] : b_q[idx];
    assign last_limb = (idx == LAST_IDX);
    assign s         = s_q;

    adder32 u_adder (
        .a    (limb_a),
        .b    (limb_b),
        .cin  (c_q),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_limb) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Result, cout and ovf are only rewritten during RUN, so they hold through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            idx   <= '0;
            c_q   <= 1'b0;
            s_q   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= sub;
                        c_q   <= sub | cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    s_q[idx] <= limb_sum;
                    c_q      <= limb_cout;
                    idx      <= idx + 1'b1;
                    if (last_limb) begin
                        cout <= limb_cout;
                        ovf  <= (limb_a[31] == limb_b[31]) & (limb_sum[31] != limb_a[31]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed corner cases plus
// randomized operations against a cycle-level behavioural model.

module tb_wide_add_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout, ovf;

    int vectors    = 0;
    int miscompares = 0;
    bit checking   = 0;

    logic [W-1:0] last_s;
    logic         last_cout, last_ovf;

    // Model state: what the outputs must be, derived from handshakes and latency.
    logic         m_in_ready, m_out_valid;
    int           m_busy;
    logic [W-1:0] m_s, p_s;
    logic         m_cout, m_ovf, p_cout, p_ovf;

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    // Whole-width reference: unsigned W+1 bit result for s/cout, signed W+1 bit for ovf.
    task automatic ref_op(input logic [W-1:0] ra, rb, input logic rcin, rsub,
                          output logic [W-1:0] rs, output logic rcout, output logic rovf);
        logic [W:0]        u;
        logic signed [W:0] sa, sb, r;
        sa = {ra[W-1], ra};
        sb = {rb[W-1], rb};
        if (rsub) begin
            u     = {1'b0, ra} - {1'b0, rb};
            rcout = ~u[W];
            r     = sa - sb;
        end else begin
            u     = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
            rcout = u[W];
            r     = sa + sb + $signed({{W{1'b0}}, rcin});
        end
        rs   = u[W-1:0];
        rovf = r[W] ^ r[W-1];
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_in_ready  = 1'b1;
            m_out_valid = 1'b0;
            m_busy      = 0;
            m_s         = '0;
            m_cout      = 1'b0;
            m_ovf       = 1'b0;
        end else if (m_in_ready) begin
            if (in_valid) begin
                ref_op(a, b, cin, sub, p_s, p_cout, p_ovf);
                m_in_ready = 1'b0;
                m_busy     = WORDS;
            end
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_out_valid = 1'b1;
                m_s         = p_s;
                m_cout      = p_cout;
                m_ovf       = p_ovf;
            end
        end else if (m_out_valid && out_ready) begin
            m_out_valid = 1'b0;
            m_in_ready  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check_val("in_ready", W'(in_ready), W'(m_in_ready));
            check_val("out_valid", W'(out_valid), W'(m_out_valid));
            if (m_busy == 0) begin
                check_val("s", s, m_s);
                check_val("cout", W'(cout), W'(m_cout));
                check_val("ovf", W'(ovf), W'(m_ovf));
            end
        end
    end

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 3))
                0:       v[32*i +: 32] = 32'h0000_0000;
                1:       v[32*i +: 32] = 32'hFFFF_FFFF;
                default: v[32*i +: 32] = $urandom;
            endcase
        end
        return v;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] op_a, op_b, input logic op_cin, op_sub,
                                 input int hold, input bit chk_carry);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (in_ready !== 1'b1) begin
            fail_now("wait_in_ready");
            return;
        end
        a        = op_a;
        b        = op_b;
        cin      = op_cin;
        sub      = op_sub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = rand_wide();
        b        = rand_wide();
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
        k = 0;
        while (1) begin
            if (chk_carry) check_val("c_q_ripple", W'(dut.c_q), W'(1));
            if (out_valid === 1'b1 || k >= 100) break;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
        if (out_valid !== 1'b1) begin
            fail_now("wait_out_valid");
            return;
        end
        check_val("latency", W'(k), W'(WORDS));
        last_s    = s;
        last_cout = cout;
        last_ovf  = ovf;
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            a        = rand_wide();
            @(negedge clk);
            check_val("hold_out_valid", W'(out_valid), W'(1));
            check_val("hold_in_ready", W'(in_ready), W'(0));
            check_val("hold_s", s, last_s);
        end
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("ready_after_ack", W'(in_ready), W'(1));
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] es, input logic ec, eo);
        check_val({name, "_s"}, last_s, es);
        check_val({name, "_cout"}, W'(last_cout), W'(ec));
        check_val({name, "_ovf"}, W'(last_ovf), W'(eo));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ones, max_pos, min_neg, big;
        ones    = '1;
        max_pos = {1'b0, {(W-1){1'b1}}};
        min_neg = {1'b1, {(W-1){1'b0}}};
        big     = '0;
        big[32] = 1'b1;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checking = 1;
        check_val("reset_in_ready", W'(in_ready), W'(1));
        check_val("reset_out_valid", W'(out_valid), W'(0));
        check_val("reset_s", s, '0);

        applyStimulus('0, '0, 1'b0, 1'b0, 0, 0);
        checkOutput("zero", '0, 1'b0, 1'b0);

        applyStimulus(ones, '0, 1'b1, 1'b0, 0, 1);
        checkOutput("ripple", '0, 1'b1, 1'b0);

        applyStimulus(big, W'(1), 1'b0, 1'b1, 0, 0);
        checkOutput("sub_borrow", W'(32'hFFFF_FFFF), 1'b1, 1'b0);

        applyStimulus('0, W'(1), 1'b1, 1'b1, 0, 0);
        checkOutput("sub_neg", ones, 1'b0, 1'b0);

        applyStimulus(max_pos, W'(1), 1'b0, 1'b0, 0, 0);
        checkOutput("overflow", min_neg, 1'b0, 1'b1);

        applyStimulus(rand_wide(), rand_wide(), 1'b1, 1'b0, 5, 0);

        // Reset lands while the second limb is being summed.
        a = rand_wide(); b = rand_wide(); cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_run_in_ready", W'(in_ready), W'(1));
        check_val("rst_run_out_valid", W'(out_valid), W'(0));
        check_val("rst_run_s", s, '0);
        repeat (WORDS + 2) begin
            @(negedge clk);
            check_val("rst_no_pulse", W'(out_valid), W'(0));
        end

        for (int n = 0; n < 1024; n++) begin
            applyStimulus(rand_wide(), rand_wide(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 0, 0);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
